// File: rtl/score_display_scan_pkg.sv
// Shared types and segment constants for the score display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package score_disp_pkg;

  typedef enum logic {S_BLANK, S_LIT} scan_state_t;

  typedef enum logic [1:0] {D_ONES, D_TENS, D_HUNDREDS} digit_sel_t;

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Entry N holds the pattern for digit N (entry 9 is the leftmost element).
  localparam logic [9:0][6:0] SEG7_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [2:0] digit_onehot(digit_sel_t d);
    case (d)
      D_TENS:     return 3'b010;
      D_HUNDREDS: return 3'b100;
      default:    return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/score_display_scan_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG7_TABLE[bcd];
  end

endmodule

// File: rtl/score_display_scan.sv
// Time-multiplexed 3-digit score display with frame-aligned snapshots and dead time.
// Optional blinking of the high-score display is enabled by defining SCORE_DISP_BLINK_EN.
module score_display_scan
  import score_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_hundreds,
  input  logic       isGameComplete,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

  scan_state_t   state, next_state;
  digit_sel_t    digit, next_digit;
  logic [TW-1:0] timer;
  logic [3:0]    snap_ones, snap_tens, snap_hund;
  logic [3:0]    sel_bcd;
  logic [6:0]    sel_seg, seg_nxt;
  logic [2:0]    an_nxt;
  logic          load_snap, show_digit, disp_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BLANK;
      digit <= D_ONES;
      timer <= '0;
    end else begin
      state <= next_state;
      digit <= next_digit;
      timer <= (next_state != state) ? '0 : timer + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_digit = digit;
    if (state == S_BLANK) begin
      if (timer == BLANK_LAST) next_state = S_LIT;
    end else if (timer == DIGIT_LAST) begin
      next_state = S_BLANK;
      case (digit)
        D_ONES:  next_digit = D_TENS;
        D_TENS:  next_digit = D_HUNDREDS;
        default: next_digit = D_ONES;
      endcase
    end
  end

  assign load_snap = (state == S_LIT) && (digit == D_HUNDREDS) && (timer == DIGIT_LAST);

  // Leading zeros are suppressed; any non-zero code (including invalid ones) keeps lower digits lit.
  always_comb begin
    case (digit)
      D_TENS: begin
        sel_bcd    = snap_tens;
        show_digit = (snap_hund != 4'd0) || (snap_tens != 4'd0);
      end
      D_HUNDREDS: begin
        sel_bcd    = snap_hund;
        show_digit = (snap_hund != 4'd0);
      end
      default: begin
        sel_bcd    = snap_ones;
        show_digit = 1'b1;
      end
    endcase
    an_nxt  = '0;
    seg_nxt = SEG_OFF;
    if ((next_state == S_LIT) && show_digit && disp_on) begin
      an_nxt  = digit_onehot(digit);
      seg_nxt = sel_seg;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd(sel_bcd),
    .seg(sel_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= '0;
      frame_done <= 1'b0;
      snap_ones  <= '0;
      snap_tens  <= '0;
      snap_hund  <= '0;
    end else begin
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= load_snap;
      if (load_snap) begin
        snap_ones <= bcd_ones;
        snap_tens <= bcd_tens;
        snap_hund <= bcd_hundreds;
      end
    end
  end

`ifdef SCORE_DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // The phase for the coming frame is decided at the same edge that snapshots isGameComplete.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (load_snap) begin
      if (!isGameComplete) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign disp_on = blink_on;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_game_complete;
  assign unused_game_complete = isGameComplete;
  assign disp_on = 1'b1;
`endif

endmodule

// File: tb/tb_score_display_scan.sv
// Self-checking bench for score_display_scan using a frame-position reference model.
module tb_score_display_scan;

  localparam int DC   = 4;
  localparam int BC   = 2;
  localparam int BF   = 2;
  localparam int SLOT = DC + BC;
  localparam int F    = 3 * SLOT;

  logic       clk;
  logic       rst;
  logic [3:0] bcd_ones, bcd_tens, bcd_hundreds;
  logic       isGameComplete;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: cycle index since reset, frame snapshot, blink state.
  int k;
  int snap [3];
  int phase_on;
  int blink_cnt;

  score_display_scan #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bcd_ones(bcd_ones),
    .bcd_tens(bcd_tens),
    .bcd_hundreds(bcd_hundreds),
    .isGameComplete(isGameComplete),
    .seg(seg),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 9) < 4) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  // Advances one clock; the model consumes the inputs present at the edge.
  task automatic applyStimulus(input bit do_rst);
    rst = do_rst;
    if (do_rst) begin
      k = 0;
      snap = '{0, 0, 0};
      phase_on = 1;
      blink_cnt = 0;
    end else begin
      k++;
      if (k % F == 0) begin
        snap[0] = int'(bcd_ones);
        snap[1] = int'(bcd_tens);
        snap[2] = int'(bcd_hundreds);
`ifdef SCORE_DISP_BLINK_EN
        if (isGameComplete) begin
          blink_cnt++;
          if (blink_cnt == BF) begin
            blink_cnt = 0;
            phase_on = 1 - phase_on;
          end
        end else begin
          phase_on = 1;
          blink_cnt = 0;
        end
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    int pos, d;
    bit visible;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    logic exp_fd;
    pos = k % F;
    d = pos / SLOT;
    visible = ((pos % SLOT) >= BC) && (phase_on != 0);
    if (d == 2) visible = visible && (snap[2] != 0);
    if (d == 1) visible = visible && (snap[2] != 0 || snap[1] != 0);
    exp_an  = visible ? 3'(1 << d) : 3'b000;
    exp_seg = visible ? ref_seg(snap[d]) : 7'h00;
    exp_fd  = (pos == 0) && (k > 0);
    compared++;
    assert (an === exp_an) else begin
      mismatched++;
      $error("[TB] FAIL an k=%0d observed %b expected %b", k, an, exp_an);
    end
    compared++;
    assert (seg === exp_seg) else begin
      mismatched++;
      $error("[TB] FAIL seg k=%0d observed %h expected %h", k, seg, exp_seg);
    end
    compared++;
    assert (frame_done === exp_fd) else begin
      mismatched++;
      $error("[TB] FAIL frame_done k=%0d observed %b expected %b", k, frame_done, exp_fd);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      applyStimulus(1'b0);
      checkOutput();
    end
  endtask

  task automatic setDigits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bcd_hundreds = h;
    bcd_tens     = t;
    bcd_ones     = o;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    isGameComplete = 1'b0;
    setDigits(4'd1, 4'd2, 4'd3);

    // Reset state, then two frames with digits 1/2/3 held.
    applyStimulus(1'b1);
    checkOutput();
    runCycles(2 * F);

    // Leading-zero and dash cases, each held across two full frames.
    setDigits(4'd0, 4'd0, 4'd5);
    runCycles(2 * F);
    setDigits(4'd0, 4'd0, 4'd0);
    runCycles(2 * F);
    setDigits(4'd1, 4'd0, 4'd0);
    runCycles(2 * F);
    setDigits(4'd0, 4'hC, 4'd7);
    runCycles(2 * F);

    // Mid-frame change during the tens slot must wait for the next frame.
    setDigits(4'd1, 4'd2, 4'd3);
    runCycles(F - (k % F));
    runCycles(F + SLOT + BC + 1);
    setDigits(4'd4, 4'd5, 4'd6);
    runCycles(2 * F);

    // Random digits changing at random points in the frame.
    for (int i = 0; i < 30; i++) begin
      setDigits(rand_digit(), rand_digit(), rand_digit());
      runCycles($urandom_range(1, F + 5));
    end

    // Reset in the middle of the tens lit slot.
    setDigits(4'd9, 4'd8, 4'd7);
    runCycles(F - (k % F) + SLOT + BC + 1);
    applyStimulus(1'b1);
    checkOutput();
    runCycles(2 * F);

    // High-score display held, then released.
    isGameComplete = 1'b1;
    setDigits(4'd2, 4'd5, 4'd0);
    runCycles(6 * F);
    isGameComplete = 1'b0;
    runCycles(2 * F);

    // Random game-complete toggling with random digits.
    for (int i = 0; i < 12; i++) begin
      isGameComplete = 1'($urandom_range(0, 1));
      setDigits(rand_digit(), rand_digit(), rand_digit());
      runCycles($urandom_range(F, 3 * F));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
